// File: rtl/s2p_lane_arbiter.sv
// Round-robin arbiter that acks one s2p lane at a time and forwards its word downstream with a lane tag.
// Define S2P_ARB_TIMEOUT_EN to drop words that stall in SEND for TIMEOUT cycles.
module s2p_lane_arbiter #(
    parameter int LANES   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [LANES-1:0]         lane_valid_i,
    input  logic [LANES*WIDTH-1:0]   lane_data_i,
    output logic [LANES-1:0]         lane_ack_o,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    output logic [$clog2(LANES)-1:0] out_lane_o,
    input  logic                     out_ready_i,
`ifdef S2P_ARB_TIMEOUT_EN
    output logic                     drop_pulse_o,
    output logic [7:0]               drop_cnt_o,
`endif
    output logic                     busy_o
);

    localparam int LW = $clog2(LANES);

    if (LANES < 2 || LANES > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : gBadParams
        $error("s2p_lane_arbiter: LANES or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]    g_q, g_d;
    logic [LW-1:0]    out_lane_q, out_lane_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [LW-1:0]    searchIdx;
    logic [LW-1:0]    pickLane;
    logic             pickFound;

`ifdef S2P_ARB_TIMEOUT_EN
    logic [7:0] stall_q, stall_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_pulse_q, drop_pulse_d;
`endif

    // Search starts one past the last served lane, so that lane gets lowest priority next round.
    always_comb begin
        searchIdx = '0;
        pickLane  = '0;
        pickFound = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            searchIdx = LW'((int'(ptr_q) + k) % LANES);
            if (!pickFound && lane_valid_i[searchIdx]) begin
                pickFound = 1'b1;
                pickLane  = searchIdx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        out_data_d = out_data_q;
        out_lane_d = out_lane_q;
`ifdef S2P_ARB_TIMEOUT_EN
        stall_d      = stall_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    g_d     = pickLane;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A lane that dropped valid here has resynced; ptr stays put so it keeps its turn.
                if (lane_valid_i[g_q]) begin
                    out_data_d = lane_data_i[int'(g_q)*WIDTH +: WIDTH];
                    out_lane_d = g_q;
                    state_d    = SEND;
`ifdef S2P_ARB_TIMEOUT_EN
                    stall_d    = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    ptr_d   = g_q;
                    state_d = IDLE;
                end
`ifdef S2P_ARB_TIMEOUT_EN
                else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == 8'(TIMEOUT)) begin
                        ptr_d        = g_q;
                        state_d      = IDLE;
                        drop_pulse_d = 1'b1;
                        drop_cnt_d   = drop_cnt_q + {7'd0, drop_cnt_q != 8'hFF};
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= LW'(LANES - 1);
            g_q        <= '0;
            out_data_q <= '0;
            out_lane_q <= '0;
`ifdef S2P_ARB_TIMEOUT_EN
            stall_q      <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            out_data_q <= out_data_d;
            out_lane_q <= out_lane_d;
`ifdef S2P_ARB_TIMEOUT_EN
            stall_q      <= stall_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
`endif
        end
    end

    assign lane_ack_o  = (state_q == GRANT) ? (LANES'(1) << g_q) : '0;
    assign out_valid_o = (state_q == SEND);
    assign out_data_o  = out_data_q;
    assign out_lane_o  = out_lane_q;
    assign busy_o      = (state_q != IDLE);
`ifdef S2P_ARB_TIMEOUT_EN
    assign drop_pulse_o = drop_pulse_q;
    assign drop_cnt_o   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Bench for s2p_lane_arbiter: transaction-level model compared every cycle plus directed literal checks.
// Build with S2P_ARB_TIMEOUT_EN defined to also exercise the stall-drop path.
module tb_s2p_lane_arbiter;

    localparam int LANES   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b1;
    logic [LANES-1:0]       laneValid = '0;
    logic [LANES*WIDTH-1:0] laneData = 32'h44A52211;
    logic                   outReady = 1'b1;
    logic [LANES-1:0]       laneAck;
    logic                   outValid;
    logic [WIDTH-1:0]       outData;
    logic [1:0]             outLane;
    logic                   busy;
`ifdef S2P_ARB_TIMEOUT_EN
    logic                   dropPulse;
    logic [7:0]             dropCnt;
`endif

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int ackLanes[$];
    int ackCycles[$];

    always #5 clk = ~clk;

    s2p_lane_arbiter #(.LANES(LANES), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lane_valid_i (laneValid),
        .lane_data_i  (laneData),
        .lane_ack_o   (laneAck),
        .out_valid_o  (outValid),
        .out_data_o   (outData),
        .out_lane_o   (outLane),
        .out_ready_i  (outReady),
`ifdef S2P_ARB_TIMEOUT_EN
        .drop_pulse_o (dropPulse),
        .drop_cnt_o   (dropCnt),
`endif
        .busy_o       (busy)
    );

    // Model state: which lane is being acked (-1 none), whether a word is held, and the rotation pointer.
    int          mAck = -1;
    bit          mHave = 1'b0;
    logic [7:0]  mWord = '0;
    int          mLane = 0;
    int          mPtr = LANES - 1;
    int          mStall = 0;
    bit          mDrop = 1'b0;
    int          mDropCnt = 0;

    function automatic int rrPick(input int ptr, input logic [LANES-1:0] v);
        for (int off = 1; off <= LANES; off++) begin
            if (v[(ptr + off) % LANES]) return (ptr + off) % LANES;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [LANES-1:0] valid, input logic ready);
        laneValid = valid;
        outReady  = ready;
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic waitOutValid(input string name);
        int n = 0;
        while (outValid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(outValid), 32'd1);
    endtask

    task automatic waitAck(input string name, input logic [LANES-1:0] expAck);
        int n = 0;
        while (laneAck === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(laneAck), 32'(expAck));
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mAck = -1; mHave = 1'b0; mWord = '0; mLane = 0; mPtr = LANES - 1;
            mStall = 0; mDrop = 1'b0; mDropCnt = 0;
        end else begin
            mDrop = 1'b0;
            if (mHave) begin
                if (outReady) begin
                    mPtr  = mLane;
                    mHave = 1'b0;
                end
`ifdef S2P_ARB_TIMEOUT_EN
                else begin
                    mStall++;
                    if (mStall >= TIMEOUT) begin
                        mHave = 1'b0;
                        mPtr  = mLane;
                        mDrop = 1'b1;
                        if (mDropCnt < 255) mDropCnt++;
                    end
                end
`endif
            end else if (mAck >= 0) begin
                if (laneValid[mAck]) begin
                    mHave  = 1'b1;
                    mWord  = laneData[mAck*WIDTH +: WIDTH];
                    mLane  = mAck;
                    mStall = 0;
                end
                mAck = -1;
            end else begin
                mAck = rrPick(mPtr, laneValid);
            end
        end
    end

    always @(negedge clk) begin
        cycle++;
        checkOutput("ack",      32'(laneAck),  (mAck >= 0) ? (32'd1 << mAck) : 32'd0);
        checkOutput("outValid", 32'(outValid), 32'(mHave));
        checkOutput("outData",  32'(outData),  32'(mWord));
        checkOutput("outLane",  32'(outLane),  32'(mLane));
        checkOutput("busy",     32'(busy),     32'((mAck >= 0) || mHave));
`ifdef S2P_ARB_TIMEOUT_EN
        checkOutput("dropPulse", 32'(dropPulse), 32'(mDrop));
        checkOutput("dropCnt",   32'(dropCnt),   32'(mDropCnt));
`endif
        if (laneAck !== '0) begin
            for (int i = 0; i < LANES; i++) begin
                if (laneAck[i]) ackLanes.push_back(i);
            end
            ackCycles.push_back(cycle);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired time=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expOrder[5] = '{0, 1, 2, 3, 0};
        int stallCount;

        // Reset values
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ack",   32'(laneAck),  32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_data",  32'(outData),  32'd0);
        checkOutput("rst_lane",  32'(outLane),  32'd0);
        checkOutput("rst_busy",  32'(busy),     32'd0);
        #2 reset_n = 1'b1;

        // Single lane 2 request: ack next cycle, word the cycle after
        @(negedge clk);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("t1_ack", 32'(laneAck), 32'h4);
        @(negedge clk);
        checkOutput("t1_valid", 32'(outValid), 32'd1);
        checkOutput("t1_data",  32'(outData),  32'hA5);
        checkOutput("t1_lane",  32'(outLane),  32'd2);
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("t1_drop", 32'(outValid), 32'd0);

        // All lanes requesting from reset: order 0,1,2,3,0, three cycles apart
        doReset();
        ackLanes.delete();
        ackCycles.delete();
        applyStimulus(4'b1111, 1'b1);
        repeat (16) @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t2_count", 32'(ackLanes.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < ackLanes.size(); i++) begin
            checkOutput("t2_order", 32'(ackLanes[i]), 32'(expOrder[i]));
            if (i > 0) checkOutput("t2_spacing", 32'(ackCycles[i] - ackCycles[i-1]), 32'd3);
        end

        // Back-pressure: word held stable, no new acks while stalled
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0);
        waitOutValid("t3_wait");
        laneValid = 4'b0000;
        repeat (10) begin
            @(negedge clk);
            checkOutput("t3_data", 32'(outData), 32'h11);
            checkOutput("t3_lane", 32'(outLane), 32'd0);
            checkOutput("t3_ack",  32'(laneAck), 32'd0);
        end
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("t3_accept", 32'(outValid), 32'd0);

        // Lane 1 resyncs during GRANT: nothing forwarded, lane 1 keeps priority
        @(negedge clk);
        applyStimulus(4'b0010, 1'b1);
        waitAck("t4_ack", 4'b0010);
        laneValid = 4'b0000;
        @(negedge clk);
        checkOutput("t4_novalid", 32'(outValid), 32'd0);
        checkOutput("t4_idle",    32'(busy),     32'd0);
        applyStimulus(4'b0011, 1'b1);
        @(negedge clk);
        checkOutput("t4_rewin", 32'(laneAck), 32'h2);
        laneValid = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset during SEND: outputs clear at once, pointer back to lane 3
        applyStimulus(4'b1111, 1'b0);
        waitOutValid("t5_wait");
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t5_valid", 32'(outValid), 32'd0);
        checkOutput("t5_ack",   32'(laneAck),  32'd0);
        checkOutput("t5_busy",  32'(busy),     32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        outReady = 1'b1;
        #1;
        checkOutput("t5_noack", 32'(laneAck), 32'd0);
        @(negedge clk);
        checkOutput("t5_first", 32'(laneAck), 32'h1);
        laneValid = 4'b0000;
        repeat (3) @(negedge clk);

`ifdef S2P_ARB_TIMEOUT_EN
        // Stall timeout: word dropped after TIMEOUT stalled cycles
        applyStimulus(4'b0100, 1'b0);
        waitOutValid("t6_wait");
        laneValid = 4'b0000;
        stallCount = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dropPulse === 1'b1) break;
            if (outValid === 1'b1) stallCount++;
        end
        checkOutput("t6_pulse",   32'(dropPulse), 32'd1);
        checkOutput("t6_held",    32'(stallCount), 32'(TIMEOUT));
        checkOutput("t6_cnt",     32'(dropCnt),   32'd1);
        checkOutput("t6_novalid", 32'(outValid),  32'd0);
        applyStimulus(4'b1010, 1'b1);
        @(negedge clk);
        checkOutput("t6_next", 32'(laneAck), 32'h8);
        laneValid = 4'b0000;
        repeat (3) @(negedge clk);
`else
        stallCount = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
